// File: rtl/id_pipe_if.sv
// Bundles the id_pipe fetch-side, regfile, EX-bypass and EX-side signals.
// slave is the decode stage's view and master is the surrounding pipeline's view.
interface id_pipe_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  // fetch side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_pc;
  logic [31:0]     in_inst;
  // regfile read ports
  logic [RAW-1:0]  raddr1;
  logic [RAW-1:0]  raddr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  // in-flight EX write
  logic            ex_we;
  logic [RAW-1:0]  ex_waddr;
  logic [XLEN-1:0] ex_wdata;
  // EX side
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_pc;
  logic [3:0]      out_aluop;
  logic [1:0]      out_alusel;
  logic [XLEN-1:0] out_src1;
  logic [XLEN-1:0] out_src2;
  logic [RAW-1:0]  out_waddr;
  logic            out_we;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_pc, in_inst, rdata1, rdata2,
    input  ex_we, ex_waddr, ex_wdata, out_ready,
    output in_ready, raddr1, raddr2,
    output out_valid, out_pc, out_aluop, out_alusel,
    output out_src1, out_src2, out_waddr, out_we, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_inst, rdata1, rdata2,
    output ex_we, ex_waddr, ex_wdata, out_ready,
    input  in_ready, raddr1, raddr2,
    input  out_valid, out_pc, out_aluop, out_alusel,
    input  out_src1, out_src2, out_waddr, out_we, out_illegal
  );
endinterface

// File: rtl/id_pipe.sv
// Instruction-decode stage: decodes, reads operands, stalls or bypasses on EX hazards, and feeds one output register.
// Define ID_FWD_EN to bypass ex_wdata into the operands instead of stalling on a hazard.
module id_pipe #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_flush,
  id_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_LUI = 4'd6
  } aluop_e;

  typedef enum logic [1:0] {
    SEL_NOP   = 2'd0,
    SEL_LOGIC = 2'd1,
    SEL_ARITH = 2'd2
  } alusel_e;

`ifdef ID_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [31:0]     w_inst;
  logic [RAW-1:0]  w_rd;
  logic [RAW-1:0]  w_rj;
  logic [RAW-1:0]  w_rk;
  logic [XLEN-1:0] w_imm_ui12;
  logic [XLEN-1:0] w_imm_si12;
  logic [XLEN-1:0] w_imm_lui;

  assign w_inst     = bus.in_inst;
  assign w_rd       = RAW'(w_inst[4:0]);
  assign w_rj       = RAW'(w_inst[9:5]);
  assign w_rk       = RAW'(w_inst[14:10]);
  assign w_imm_ui12 = XLEN'(w_inst[21:10]);
  assign w_imm_si12 = XLEN'($signed(w_inst[21:10]));
  assign w_imm_lui  = XLEN'($signed({w_inst[24:5], 12'b0}));

  assign bus.raddr1 = w_rj;
  assign bus.raddr2 = w_rk;

  aluop_e          w_op;
  alusel_e         w_sel;
  logic            w_is_3r;
  logic            w_is_lui;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;

  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_op      = ALU_NOP;
    w_sel     = SEL_NOP;
    w_is_3r   = 1'b0;
    w_is_lui  = 1'b0;
    w_illegal = 1'b1;
    w_imm     = '0;

    // 2RI12 forms
    case (w_inst[31:22])
      10'h00E: begin w_op = ALU_OR;  w_sel = SEL_LOGIC; w_imm = w_imm_ui12; w_illegal = 1'b0; end
      10'h00D: begin w_op = ALU_AND; w_sel = SEL_LOGIC; w_imm = w_imm_ui12; w_illegal = 1'b0; end
      10'h00F: begin w_op = ALU_XOR; w_sel = SEL_LOGIC; w_imm = w_imm_ui12; w_illegal = 1'b0; end
      10'h00A: begin w_op = ALU_ADD; w_sel = SEL_ARITH; w_imm = w_imm_si12; w_illegal = 1'b0; end
      default: ;
    endcase

    if (w_inst[31:25] == 7'h0A) begin
      w_op      = ALU_LUI;
      w_sel     = SEL_ARITH;
      w_imm     = w_imm_lui;
      w_is_lui  = 1'b1;
      w_illegal = 1'b0;
    end

    // 3R forms
    case (w_inst[31:15])
      17'h00020: begin w_op = ALU_ADD; w_sel = SEL_ARITH; w_is_3r = 1'b1; w_illegal = 1'b0; end
      17'h00022: begin w_op = ALU_SUB; w_sel = SEL_ARITH; w_is_3r = 1'b1; w_illegal = 1'b0; end
      17'h00029: begin w_op = ALU_AND; w_sel = SEL_LOGIC; w_is_3r = 1'b1; w_illegal = 1'b0; end
      17'h0002A: begin w_op = ALU_OR;  w_sel = SEL_LOGIC; w_is_3r = 1'b1; w_illegal = 1'b0; end
      17'h0002B: begin w_op = ALU_XOR; w_sel = SEL_LOGIC; w_is_3r = 1'b1; w_illegal = 1'b0; end
      default: ;
    endcase
  end

  // r0 can never match: the zero check on ex_waddr excludes it.
  logic w_hit1;
  logic w_hit2;
  logic w_hazard;

  assign w_hit1   = bus.ex_we && (bus.ex_waddr != '0) && (bus.ex_waddr == w_rj);
  assign w_hit2   = bus.ex_we && (bus.ex_waddr != '0) && (bus.ex_waddr == w_rk) && w_is_3r;
  assign w_hazard = !FWD && (w_hit1 || w_hit2);

  logic [XLEN-1:0] w_rj_val;
  logic [XLEN-1:0] w_rk_val;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic            w_we;
  logic [RAW-1:0]  w_waddr;

  assign w_rj_val = (w_rj == '0)       ? '0           :
                    (FWD && w_hit1)    ? bus.ex_wdata : bus.rdata1;
  assign w_rk_val = (w_rk == '0)       ? '0           :
                    (FWD && w_hit2)    ? bus.ex_wdata : bus.rdata2;
  assign w_src1   = (w_is_lui || w_illegal) ? '0 : w_rj_val;
  assign w_src2   = w_is_3r ? w_rk_val : w_imm;
  assign w_we     = !w_illegal && (w_rd != '0);
  assign w_waddr  = w_illegal ? '0 : w_rd;

  logic            r_out_valid;
  logic [31:0]     r_pc;
  aluop_e          r_aluop;
  alusel_e         r_alusel;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_src2;
  logic [RAW-1:0]  r_waddr;
  logic            r_we;
  logic            r_illegal;
  logic            w_in_ready;
  logic            w_accept;

  assign w_in_ready = !rst && !i_flush && !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Priority: reset, then flush, then a new accept, then drain on out_ready.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the payload fields are reset too, so EX never sees X on a cleared stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_aluop     <= ALU_NOP;
      r_alusel    <= SEL_NOP;
      r_src1      <= '0;
      r_src2      <= '0;
      r_waddr     <= '0;
      r_we        <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_pc        <= bus.in_pc;
      r_aluop     <= w_op;
      r_alusel    <= w_sel;
      r_src1      <= w_src1;
      r_src2      <= w_src2;
      r_waddr     <= w_waddr;
      r_we        <= w_we;
      r_illegal   <= w_illegal;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_pc      = r_pc;
  assign bus.out_aluop   = r_aluop;
  assign bus.out_alusel  = r_alusel;
  assign bus.out_src1    = r_src1;
  assign bus.out_src2    = r_src2;
  assign bus.out_waddr   = r_waddr;
  assign bus.out_we      = r_we;
  assign bus.out_illegal = r_illegal;

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width (XLEN >= 32).
REQ-002 Parameter RAW, default 5, register address width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flush  in  1  discard output register contents.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 in_pc / in_inst  in  32 / 32  instruction address and word.
REQ-008 raddr1 / raddr2  out  RAW each  regfile read ports, combinational: inst[9:5] (rj) and inst[14:10] (rk).
REQ-009 rdata1 / rdata2  in  XLEN each  regfile read data, same cycle.
REQ-010 ex_we, ex_waddr, ex_wdata  in  1, RAW, XLEN  in-flight EX-stage write.
REQ-011 out_valid / out_ready  out / in  1 / 1  EX-side handshake.
REQ-012 out_pc, out_aluop(4), out_alusel(2), out_src1, out_src2 (XLEN), out_waddr (RAW), out_we, out_illegal  out  registered decode results.

Function
REQ-013 Decode: ori/andi/xori (inst[31:22] = 0x00E/0x00D/0x00F, ui12 zero-extended); addi.w (0x00A, si12 sign-extended); lu12i.w (inst[31:25] = 0x0A, {si20,12'b0} sign-extended); add.w/sub.w/and/or/xor (inst[31:15] = 0x20/0x22/0x29/0x2A/0x2B).
REQ-014 aluop: ADD=1, SUB=2, AND=3, OR=4, XOR=5, LUI=6, NOP=0; alusel: NOP=0, LOGIC=1, ARITH=2 (add/sub/lui).
REQ-015 src1 = rj value (zero for lu12i.w); src2 = rk value for 3-register ops, else the extended immediate.
REQ-016 Register 0 reads as zero regardless of rdata, never matches a hazard, and writes to rd=0 produce out_we=0.
REQ-017 Undecodable word: out_illegal=1, out_we=0, aluop/alusel NOP, still handshaken downstream.
REQ-018 in_ready = !flush && !hazard && (!out_valid || out_ready).
REQ-019 Accept (in_valid && in_ready) loads the output register; out_valid rises the next cycle (1-cycle latency, 1 instr/cycle sustained).
REQ-020 No accept and out_ready=1: out_valid clears. out_ready=0: all out_* hold stable.
REQ-021 flush clears out_valid next edge and blocks accept in the same cycle; flush wins over a simultaneous accept.
REQ-022 Hazard: ex_we=1, ex_waddr != 0, and equal to a source the instruction actually reads (rj always, rk only for 3-register ops).

Reset
REQ-023 rst clears out_valid, out_we, out_illegal, out_aluop, out_alusel, out_pc, out_src1, out_src2, out_waddr to 0.
REQ-024 rst overrides flush and accept; in_ready = 0 while rst is high.
REQ-025 rst mid-stream discards the held instruction; the first accept after reset deassertion is possible the following cycle.

Configuration
REQ-026 Macro ID_FWD_EN defined: hazard sources take ex_wdata instead of rdata; hazard never stalls.
REQ-027 Macro ID_FWD_EN undefined: hazard forces in_ready=0 until ex_we drops or ex_waddr changes; rdata is used.

Verification
REQ-028 ori r1,r0,0xFF (0x0383FC01) -> next cycle out_valid=1, aluop=OR, alusel=LOGIC, src1=0, src2=0x000000FF, waddr=1, we=1.
REQ-029 addi.w r2,r1,-1 (0x02BFFC22), rdata1=0x10 -> src1=0x10, src2=0xFFFFFFFF, aluop=ADD, waddr=2.
REQ-030 add.w r3,r1,r2 (0x00100823), ex_we=1, ex_waddr=1, ex_wdata=0x1234 -> with ID_FWD_EN src1=0x1234 and no stall; without it in_ready=0 until ex_we=0, then src1=rdata1.
REQ-031 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 -> the next instruction is loaded the following edge.
REQ-032 in_inst=0xFFFFFFFF -> out_illegal=1, out_we=0; flush asserted together with an accept -> out_valid=0 next cycle and the instruction is not consumed.
